// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for the up/down modulo counter family.
//   - MODE_WRAP / MODE_SAT : values for the counter's SATURATE parameter
//   - clog2                : ceiling log2, used to size the prescaler register
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Ceiling log2; returns 0 for values of 0 or 1, so callers apply their own minimum.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler
//   Divides enabled cycles down to count-step cycles. Every PRESCALE-th enabled
//   cycle is flagged as a step cycle. The phase freezes while enable is low and
//   is discarded by reset or clear.
// Ports
//   clk     in  1  clock, all logic on posedge
//   reset   in  1  synchronous, active-high
//   clear   in  1  synchronous clear of the prescale phase (used on load)
//   enable  in  1  advance the prescaler this cycle
//   step    out 1  this cycle is a step cycle (combinational)
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam int PW_RAW = clog2(PRESCALE);
  localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // With PRESCALE = 1, LAST is 0 so the phase never leaves 0 and step == enable.
  assign step = enable && (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      if (phase_q == LAST) phase_d = '0;
      else                 phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod
//   Parametrised up/down modulo counter with parallel load, wrap or saturate at
//   the terminal value, a clock-enable prescaler and a registered terminal-count
//   pulse.
// Parameters
//   WIDTH     counter width in bits (>= 1)
//   MAX_VAL   highest count value, 1 .. 2**WIDTH-1
//   SATURATE  MODE_WRAP (0) wraps at the terminal, MODE_SAT (1) holds there
//   PRESCALE  enabled cycles per count step (>= 1)
// Ports
//   clk         in  1      clock, all logic on posedge
//   reset       in  1      synchronous, active-high
//   enable      in  1      count enable; prescaler and counter hold when low
//   up_dn       in  1      1 = count up, 0 = count down
//   load        in  1      parallel load strobe (ignores enable)
//   load_value  in  WIDTH  value to load, clamped to MAX_VAL
//   count       out WIDTH  registered count
//   tc          out 1      registered terminal-count pulse
//   at_max      out 1      count == MAX_VAL (combinational)
//   at_zero     out 1      count == 0 (combinational)
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter longint unsigned MAX_VAL  = (WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                       : ((64'd1 << WIDTH) - 64'd1),
  parameter int              SATURATE = MODE_WRAP,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam longint unsigned MAX_LIMIT = (WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                         : ((64'd1 << WIDTH) - 64'd1);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam bit SAT = (SATURATE == MODE_SAT);

  // Reject parameter sets the counter cannot represent.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("counter_updown_mod: WIDTH must be >= 1");
    end
    if (MAX_VAL == 0 || MAX_VAL > MAX_LIMIT) begin : g_bad_max
      $error("counter_updown_mod: MAX_VAL must be in 1 .. 2**WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("counter_updown_mod: PRESCALE must be >= 1");
    end
  endgenerate

  logic             step;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;

  // Load discards any partial prescale so counting restarts from a clean phase.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (load),
    .enable (enable),
    .step   (step)
  );

  // Next-state mux: load beats step beats hold. Wrap is by explicit compare with
  // MAX_C so it stays correct when MAX_VAL is below the natural overflow point.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (step) begin
      if (up_dn) begin
        if (count_q == MAX_C) begin
          count_d = SAT ? MAX_C : '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = SAT ? '0 : MAX_C;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

endmodule
